// File: rtl/iram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : iram_arbiter_pkg
// Brief   : State encodings, read-return tags and counter sizing helper shared
//           by the instruction RAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package iram_arbiter_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_LOAD  = 2'd1,
    S_BOOT  = 2'd2
  } arb_state_t;

  // Identifies which requester owns the read data returning this cycle.
  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_LDRD  = 2'd2
  } rd_tag_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : iram_arbiter
// Brief   : Shares the single-port instruction RAM between fetch and the
//           loader/debug port. Optional boot hold with IRAM_BOOT_HOLD_EN.
// Revision: 1.0 - initial release
// ============================================================================
import iram_arbiter_pkg::*;

module iram_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_LEN = 8
) (
  input  logic          Clk,
  input  logic          Reset,
`ifdef IRAM_BOOT_HOLD_EN
  input  logic          BootDone,
`endif
  input  logic          FetchEn,
  input  logic [AW-1:0] FetchAddr,
  output logic          FetchStall,
  output logic          FetchValid,
  output logic [DW-1:0] FetchInst,
  input  logic          LdReq,
  input  logic          LdWe,
  input  logic [AW-1:0] LdAddr,
  input  logic [DW-1:0] LdWData,
  output logic          LdAck,
  output logic          LdRValid,
  output logic [DW-1:0] LdRData,
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData
);

  localparam int WW = cnt_width(MAX_WAIT);
  localparam int BW = cnt_width(BURST_LEN);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);
`ifdef IRAM_BOOT_HOLD_EN
  localparam arb_state_t RESET_STATE = S_BOOT;
`else
  localparam arb_state_t RESET_STATE = S_FETCH;
`endif

  arb_state_t    state;
  rd_tag_t       rd_tag;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt;
  logic          ld_grant;
  logic          fetch_grant;
  logic          in_boot;

`ifdef IRAM_BOOT_HOLD_EN
  assign in_boot = (state == S_BOOT);
`else
  assign in_boot = 1'b0;
`endif

  always_comb begin
    ld_grant    = 1'b0;
    fetch_grant = 1'b0;
    if (!Reset) begin
      case (state)
        S_FETCH: begin
          ld_grant    = LdReq && (!FetchEn || (wait_cnt == WAIT_MAX));
          fetch_grant = FetchEn && !ld_grant;
        end
        S_LOAD: begin
          ld_grant    = LdReq && (burst_cnt < BURST_MAX);
          fetch_grant = FetchEn && !ld_grant;
        end
`ifdef IRAM_BOOT_HOLD_EN
        S_BOOT: ld_grant = LdReq;
`endif
        default: begin
          ld_grant    = 1'b0;
          fetch_grant = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= RESET_STATE;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      rd_tag    <= TAG_NONE;
    end else begin
      // Writes return nothing, so a write grant leaves the read slot empty.
      if (ld_grant)         rd_tag <= LdWe ? TAG_NONE : TAG_LDRD;
      else if (fetch_grant) rd_tag <= TAG_FETCH;
      else                  rd_tag <= TAG_NONE;

      // Waiting only accrues while fetch owns the RAM; leaving a burst restarts it.
      if (ld_grant || state != S_FETCH)
        wait_cnt <= '0;
      else if (LdReq && wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + 1'b1;

      if (ld_grant && state != S_BOOT) burst_cnt <= burst_cnt + 1'b1;
      else                             burst_cnt <= '0;

      case (state)
        S_FETCH, S_LOAD: state <= ld_grant ? S_LOAD : S_FETCH;
`ifdef IRAM_BOOT_HOLD_EN
        S_BOOT: if (BootDone) state <= S_FETCH;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

  assign LdAck      = ld_grant;
  assign FetchStall = Reset || in_boot || (FetchEn && !fetch_grant);
  assign MemEn      = ld_grant || fetch_grant;
  assign MemWe      = ld_grant && LdWe;
  assign MemAddr    = ld_grant ? LdAddr : FetchAddr;
  assign MemWData   = LdWData;
  assign FetchValid = (rd_tag == TAG_FETCH);
  assign LdRValid   = (rd_tag == TAG_LDRD);
  assign FetchInst  = MemRData;
  assign LdRData    = MemRData;

endmodule
`default_nettype wire

// File: tb/tb_iram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_iram_arbiter
// Brief   : Self-checking bench for iram_arbiter with a cycle-level reference
//           model and RAM; covers IRAM_BOOT_HOLD_EN when that macro is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_iram_arbiter;

  localparam int AW        = 10;
  localparam int DW        = 32;
  localparam int MAX_WAIT  = 4;
  localparam int BURST_LEN = 8;
  localparam int DEPTH     = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_en, ld_req, ld_we;
  logic [AW-1:0] fetch_addr, ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          fetch_stall, fetch_valid, ld_ack, ld_rvalid;
  logic [DW-1:0] fetch_inst, ld_rdata, mem_wdata, ram_q;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
`ifdef IRAM_BOOT_HOLD_EN
  logic          boot_done = 1'b0;
`endif

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  int checks   = 0;
  int failures = 0;

  // Reference model state: owner of the RAM and the loader's waiting history.
  int            waited, burst;
  bit            loading, booting;
  bit            exp_fv, exp_lv;
  logic [DW-1:0] exp_fdata, exp_ldata;
  bit            ack_seen, fgrant_seen, stall_seen;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      ram_q <= ram[mem_addr];
    end
  end

  iram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .BURST_LEN(BURST_LEN)) dut (
    .Clk        (clk),
    .Reset      (reset),
`ifdef IRAM_BOOT_HOLD_EN
    .BootDone   (boot_done),
`endif
    .FetchEn    (fetch_en),
    .FetchAddr  (fetch_addr),
    .FetchStall (fetch_stall),
    .FetchValid (fetch_valid),
    .FetchInst  (fetch_inst),
    .LdReq      (ld_req),
    .LdWe       (ld_we),
    .LdAddr     (ld_addr),
    .LdWData    (ld_wdata),
    .LdAck      (ld_ack),
    .LdRValid   (ld_rvalid),
    .LdRData    (ld_rdata),
    .MemEn      (mem_en),
    .MemWe      (mem_we),
    .MemAddr    (mem_addr),
    .MemWData   (mem_wdata),
    .MemRData   (ram_q)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs are already applied; check combinational grants, advance
  // the model across the edge, then check the registered read returns.
  task automatic tick();
    bit g_ld, g_f;
    #1;
    if (reset) begin
      g_ld = 1'b0; g_f = 1'b0;
    end else if (booting) begin
      g_ld = ld_req; g_f = 1'b0;
    end else begin
      g_ld = ld_req && (loading ? (burst < BURST_LEN) : (!fetch_en || waited >= MAX_WAIT));
      g_f  = fetch_en && !g_ld;
    end
    ack_seen    = ld_ack;
    stall_seen  = fetch_stall;
    fgrant_seen = fetch_en && !fetch_stall;
    check("ld_ack", 32'(ld_ack), 32'(g_ld));
    check("fetch_stall", 32'(fetch_stall), 32'(reset || booting || (fetch_en && !g_f)));
    check("mem_en", 32'(mem_en), 32'(g_ld || g_f));
    check("mem_we", 32'(mem_we), 32'(g_ld && ld_we));
    if (g_ld || g_f) check("mem_addr", 32'(mem_addr), 32'(g_ld ? ld_addr : fetch_addr));
    if (g_ld && ld_we) check("mem_wdata", mem_wdata, ld_wdata);

    exp_fv = 1'b0;
    exp_lv = 1'b0;
    if (reset) begin
      waited = 0; burst = 0; loading = 1'b0;
`ifdef IRAM_BOOT_HOLD_EN
      booting = 1'b1;
`else
      booting = 1'b0;
`endif
    end else begin
      if (g_ld) begin
        if (ld_we) ref_mem[ld_addr] = ld_wdata;
        else begin exp_lv = 1'b1; exp_ldata = ref_mem[ld_addr]; end
        waited = 0;
        if (!booting) begin burst++; loading = 1'b1; end
      end else begin
        if (loading) waited = 0;
        else if (ld_req && !booting && waited < MAX_WAIT) waited++;
        burst = 0; loading = 1'b0;
      end
      if (g_f) begin exp_fv = 1'b1; exp_fdata = ref_mem[fetch_addr]; end
`ifdef IRAM_BOOT_HOLD_EN
      if (booting && boot_done) booting = 1'b0;
`endif
    end

    @(posedge clk);
    #1;
    check("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
    check("ld_rvalid", 32'(ld_rvalid), 32'(exp_lv));
    if (exp_fv) check("fetch_inst", fetch_inst, exp_fdata);
    if (exp_lv) check("ld_rdata", ld_rdata, exp_ldata);
  endtask

  task automatic ld_xfer(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int n, output int stalls);
    ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
    n = 0; stalls = 0;
    do begin
      tick();
      n++;
      if (stall_seen) stalls++;
    end while (!ack_seen && n < 40);
    ld_req = 1'b0;
    check("ld_ack_timeout", 32'(ack_seen), 32'd1);
  endtask

  task automatic release_boot();
`ifdef IRAM_BOOT_HOLD_EN
    boot_done = 1'b1;
    tick();
    boot_done = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, st, acks, gap_fetch, run1, cyc, stalls;
    bit run_open;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = init_val(i);
      ref_mem[i] = init_val(i);
    end
    reset = 1'b1; fetch_en = 1'b1; fetch_addr = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    waited = 0; burst = 0; loading = 1'b0; booting = 1'b0;

    tick();
    tick();
    reset = 1'b0;

`ifdef IRAM_BOOT_HOLD_EN
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = AW'(i);
      tick();
      if (stall_seen) stalls++;
    end
    check("t6_boot_stall", 32'(stalls), 32'd3);
    release_boot();
    tick();
    check("t6_fetch_after_boot", 32'(fgrant_seen), 32'd1);
`endif

    // Fetch streaming alone never stalls.
    fetch_en = 1'b1;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      fetch_addr = AW'(i);
      tick();
      if (stall_seen) stalls++;
    end
    check("t1_stalls", 32'(stalls), 32'd0);

    // Loader write behind busy fetch is granted once the wait budget is spent.
    fetch_addr = AW'(5);
    ld_xfer(1'b1, AW'(32'h010), 32'hCAFE_0010, n, st);
    check("t2_ack_cycle", 32'(n), 32'(MAX_WAIT + 1));
    check("t2_stall_cycles", 32'(st), 32'd1);
    fetch_en = 1'b0;
    ld_xfer(1'b0, AW'(32'h010), '0, n, st);
    check("t2_readback", ld_rdata, 32'hCAFE_0010);
    tick();

    // Long write stream: burst cap hands fetch the RAM, then the loader resumes.
    fetch_en = 1'b1; ld_req = 1'b1; ld_we = 1'b1;
    acks = 0; gap_fetch = 0; run1 = 0; cyc = 0; run_open = 1'b1;
    while (acks < 12 && cyc < 80) begin
      ld_addr    = AW'(32'h100 + acks);
      ld_wdata   = 32'hB000_0000 + 32'(acks);
      fetch_addr = AW'(cyc);
      tick();
      cyc++;
      if (ack_seen) begin
        acks++;
        if (run_open) run1++;
      end else begin
        if (acks > 0) run_open = 1'b0;
        if (acks == BURST_LEN && fgrant_seen) gap_fetch++;
      end
    end
    ld_req = 1'b0;
    check("t3_acks", 32'(acks), 32'd12);
    check("t3_first_burst", 32'(run1), 32'(BURST_LEN));
    check("t3_fetch_gap", 32'(gap_fetch), 32'(1 + MAX_WAIT));
    fetch_en = 1'b0;
    tick();

    // Loader read with fetch idle is granted immediately.
    ld_xfer(1'b0, AW'(32'h3FF), '0, n, st);
    check("t4_ack_cycle", 32'(n), 32'd1);
    check("t4_rvalid", 32'(ld_rvalid), 32'd1);
    check("t4_fvalid", 32'(fetch_valid), 32'd0);
    check("t4_rdata", ld_rdata, init_val(32'h3FF));
    tick();

    // Reset lands on the fourth write of a burst.
    for (int i = 0; i < 3; i++)
      ld_xfer(1'b1, AW'(32'h200 + i), 32'hD000_0000 + 32'(i), n, st);
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = AW'(32'h203); ld_wdata = 32'hDEAD_0003;
    reset = 1'b1;
    tick();
    check("t5_no_ack", 32'(ack_seen), 32'd0);
    reset = 1'b0; ld_req = 1'b0;
    tick();
    check("t5_rvalid_clear", 32'(ld_rvalid), 32'd0);
    release_boot();
    for (int i = 0; i < 3; i++) begin
      ld_xfer(1'b0, AW'(32'h200 + i), '0, n, st);
      check("t5_kept", ld_rdata, 32'hD000_0000 + 32'(i));
    end
    ld_xfer(1'b0, AW'(32'h203), '0, n, st);
    check("t5_not_written", ld_rdata, init_val(32'h203));
    tick();

    // Randomized mix of fetch traffic and loader reads/writes on a small window.
    for (int c = 0; c < 400; c++) begin
      fetch_en   = ($urandom_range(0, 9) < 7);
      fetch_addr = AW'($urandom_range(0, 31));
      if (!ld_req && $urandom_range(0, 3) == 0) begin
        ld_req   = 1'b1;
        ld_we    = 1'($urandom_range(0, 1));
        ld_addr  = AW'($urandom_range(0, 31));
        ld_wdata = $urandom;
      end
      tick();
      if (ack_seen) ld_req = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
